countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100_000_000: clk cycles per one-second decrement.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_p  input  1  reset, asynchronous, active-high.
REQ-004 btn_pedge  input  4  one-cycle button pulses: [0] start/pause, [1] minute +1, [2] second +1, [3] clear.
REQ-005 value  output  16  BCD remaining time {min10, min1, sec10, sec1}.
REQ-006 running  output  1  high while state is RUN.
REQ-007 alarm  output  1  high while state is ALARM.

Function
REQ-008 States SHALL be IDLE, RUN, PAUSE and ALARM; value range 00:00..59:59; min10 and sec10 never exceed 5.
REQ-009 IDLE/PAUSE: btn[1] SHALL increment minutes modulo 60 (59->00) and btn[2] seconds modulo 60 (59->00), with no carry into minutes.
REQ-010 btn[1] and btn[2] SHALL be ignored in RUN and ALARM.
REQ-011 IDLE + btn[0] with value != 0000 -> RUN, prescaler cleared to 0; with value == 0000 -> remain IDLE.
REQ-012 RUN + btn[0] -> PAUSE; PAUSE + btn[0] -> RUN; prescaler SHALL hold its count across a pause.
REQ-013 In RUN, prescaler SHALL count 0..TICKS_PER_SEC-1; on the terminal count the value SHALL decrement by one second in the same edge and the prescaler SHALL wrap to 0.
REQ-014 Decrement SHALL borrow in BCD: sec1 0->9 with sec10 -1; sec 00->59 with min -1.
REQ-015 A decrement from 00:01 SHALL give 00:00 and enter ALARM on the same edge; alarm high from the next cycle.
REQ-016 ALARM: value held at 0000; any btn_pedge bit SHALL return to IDLE and drop alarm on that edge.
REQ-017 btn[3] in any state SHALL force IDLE, value 0000, prescaler 0, alarm 0.
REQ-018 Simultaneous bits SHALL resolve by priority clear > start/pause > minute > second; lower-priority bits in that cycle are discarded.
REQ-019 A terminal tick coinciding with btn[0] in RUN SHALL apply the decrement, then enter PAUSE.
REQ-020 Outputs SHALL be registered; button effects are visible on value/running/alarm one cycle after the pulse.

Reset
REQ-021 reset_p high SHALL asynchronously force IDLE, value 0000, prescaler 0, running 0, alarm 0, preset register 0000.
REQ-022 reset_p asserted mid-RUN or mid-ALARM SHALL abandon the countdown; no alarm after release.

Configuration
REQ-023 Macro COUNTDOWN_PRESET_RELOAD_EN defined: value is captured into a preset register on every IDLE->RUN transition; ALARM exit via btn[0..2] reloads value from the preset (btn[3] still clears to 0000).
REQ-024 Macro COUNTDOWN_PRESET_RELOAD_EN undefined: no preset register; ALARM exit always leaves value 0000.

Structure
REQ-025 Shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3) and the BCD limit constants (9, 5).
REQ-026 Sub-module bcd_mod60_updown SHALL implement one BCD 00..59 digit pair with inc/dec enables and wrap/borrow-out.
REQ-027 Top SHALL instantiate bcd_mod60_updown twice (seconds, minutes) plus the FSM and prescaler.

Verification (TICKS_PER_SEC=10)
REQ-028 Set 00:03 (3x btn[2]), btn[0] -> value 0002, 0001, 0000 at 10-cycle intervals; alarm=1 the cycle after reaching 0000, running=0.
REQ-029 Set 01:00, run one tick -> value 0059 (BCD borrow across minutes).
REQ-030 Run, pause after 4 prescaler cycles, wait 50 cycles, resume -> next decrement 6 cycles after resume.
REQ-031 btn[3] and btn[0] in the same cycle during RUN at 00:30 -> IDLE, value 0000, running=0.
REQ-032 btn[0] at value 0000 in IDLE -> stays IDLE; 60x btn[2] from 00:00 -> 0000 (wrap, minutes unchanged).
REQ-033 With COUNTDOWN_PRESET_RELOAD_EN: preset 00:02, expire, btn[1] in ALARM -> IDLE, value 0002; without it -> value 0000.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared definitions for the countdown timer.
// Holds the FSM state encoding and the BCD digit limits used by the
// mod-60 digit pairs. There are no ports; other files import this package.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ONES_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX = 4'd5;
    localparam logic [7:0] MOD60_MAX    = {BCD_TENS_MAX, BCD_ONES_MAX};

endpackage

// File: rtl/countdown_timer_bcd_mod60_updown.sv
// bcd_mod60_updown: one BCD digit pair counting 00..59 with up/down enables.
// Ports:
//   clk, reset_p        clock, asynchronous active-high reset
//   clr                 synchronous clear to 00 (highest priority)
//   load, load_value    synchronous load of a BCD pair
//   inc, dec            step up / step down by one (inc wins over dec)
//   value               registered BCD pair {tens, ones}
//   carry               high while an inc wraps 59->00 or a dec borrows 00->59
module bcd_mod60_updown
    import countdown_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] value,
    output logic       carry
);

    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] up;
    logic [7:0] down;
    logic [7:0] next;

    assign tens = value[7:4];
    assign ones = value[3:0];

    always_comb begin
        up    = (ones == BCD_ONES_MAX)
              ? ((tens == BCD_TENS_MAX) ? 8'h00 : {tens + 4'd1, 4'd0})
              : {tens, ones + 4'd1};
        down  = (ones == 4'd0)
              ? ((tens == 4'd0) ? MOD60_MAX : {tens - 4'd1, BCD_ONES_MAX})
              : {tens, ones - 4'd1};
        next  = clr ? 8'h00 : load ? load_value : inc ? up : dec ? down : value;
        // Carry only reflects a step that actually takes effect this cycle.
        carry = !clr && !load
              && ((inc && value == MOD60_MAX) || (!inc && dec && value == 8'h00));
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)
            value <= 8'h00;
        else
            value <= next;
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown timer with start/pause, set and clear buttons.
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset_p     asynchronous active-high reset
//   btn_pedge   one-cycle pulses: [0] start/pause, [1] minute +1, [2] second +1, [3] clear
//   value       registered BCD remaining time {min10, min1, sec10, sec1}
//   running     registered, high while in RUN
//   alarm       registered, high while in ALARM
// Parameter TICKS_PER_SEC sets the clk cycles per one-second decrement.
// Build option COUNTDOWN_PRESET_RELOAD_EN: when defined, the time is captured
// on each IDLE->RUN start and restored when the alarm is dismissed with
// btn[0..2]; when undefined, dismissing the alarm always leaves 00:00.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
)(
    input  logic        clk,
    input  logic        reset_p,
    input  logic [3:0]  btn_pedge,
    output logic [15:0] value,
    output logic        running,
    output logic        alarm
);

    localparam int            PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TERMINAL = PW'(TICKS_PER_SEC - 1);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          clear;
    logic          start;
    logic          min_btn;
    logic          sec_btn;
    logic          tick;
    logic          is_zero;
    logic          is_last;
    logic          clr_value;
    logic          reload;
    logic          sec_inc;
    logic          sec_dec;
    logic          min_inc;
    logic          min_dec;
    logic          sec_carry;
    logic          unused_min_carry;
    logic          load;
    logic [15:0]   load_value;
    logic [7:0]    sec_value;
    logic [7:0]    min_value;

    // Button priority: clear > start/pause > minute > second.
    assign clear   = btn_pedge[3];
    assign start   = btn_pedge[0] && !clear;
    assign min_btn = btn_pedge[1] && !btn_pedge[0] && !clear;
    assign sec_btn = btn_pedge[2] && !btn_pedge[1] && !btn_pedge[0] && !clear;

    assign value   = {min_value, sec_value};
    assign is_zero = (value == 16'h0000);
    assign is_last = (value == 16'h0001);
    assign tick    = (state == RUN) && (presc == TERMINAL);

    // Minutes only borrow when the seconds pair underflows on a decrement.
    assign min_dec = sec_dec && sec_carry;

    always_comb begin
        state_next = state;
        presc_next = presc;
        clr_value  = 1'b0;
        reload     = 1'b0;
        sec_inc    = 1'b0;
        sec_dec    = 1'b0;
        min_inc    = 1'b0;
        if (clear) begin
            state_next = IDLE;
            presc_next = '0;
            clr_value  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    min_inc = min_btn;
                    sec_inc = sec_btn;
                    if (start && !is_zero) begin
                        state_next = RUN;
                        presc_next = '0;
                    end
                end
                RUN: begin
                    presc_next = tick ? '0 : presc + 1'b1;
                    // A zero value can only reach RUN by editing 00:00 in PAUSE;
                    // expire it instead of underflowing to 59:59.
                    sec_dec    = tick && !is_zero;
                    if (tick && (is_last || is_zero))
                        state_next = ALARM;
                    else if (start)
                        state_next = PAUSE;
                end
                PAUSE: begin
                    min_inc = min_btn;
                    sec_inc = sec_btn;
                    if (start)
                        state_next = RUN;
                end
                ALARM: begin
                    if (|btn_pedge) begin
                        state_next = IDLE;
                        reload     = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            state   <= state_next;
            presc   <= presc_next;
            running <= (state_next == RUN);
            alarm   <= (state_next == ALARM);
        end
    end

`ifdef COUNTDOWN_PRESET_RELOAD_EN
    logic [15:0] preset;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)
            preset <= 16'h0000;
        else if (state == IDLE && state_next == RUN)
            preset <= value;
    end

    assign load       = reload;
    assign load_value = preset;
`else
    // Without a preset, dismissing the alarm reloads the (already zero) time with 00:00.
    assign load       = reload;
    assign load_value = 16'h0000;
`endif

    bcd_mod60_updown u_sec (
        .clk        (clk),
        .reset_p    (reset_p),
        .clr        (clr_value),
        .load       (load),
        .load_value (load_value[7:0]),
        .inc        (sec_inc),
        .dec        (sec_dec),
        .value      (sec_value),
        .carry      (sec_carry)
    );

    bcd_mod60_updown u_min (
        .clk        (clk),
        .reset_p    (reset_p),
        .clr        (clr_value),
        .load       (load),
        .load_value (load_value[15:8]),
        .inc        (min_inc),
        .dec        (min_dec),
        .value      (min_value),
        .carry      (unused_min_carry)
    );

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: self-checking bench for countdown_timer with TICKS_PER_SEC=10.
module tb_countdown_timer;

    localparam int TPS = 10;

`ifdef COUNTDOWN_PRESET_RELOAD_EN
    localparam logic [15:0] RELOAD = 16'h0003;
`else
    localparam logic [15:0] RELOAD = 16'h0000;
`endif

    typedef struct {
        string       name;
        logic [15:0] value;
        logic        running;
        logic        alarm;
    } exp_t;

    typedef struct {
        logic [3:0] btn;
        exp_t       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [3:0]  btn_pedge = 4'b0000;
    logic [15:0] value;
    logic        running;
    logic        alarm;

    exp_t sb[$];
    vec_t tbl[13];
    int   checks = 0;
    int   errors = 0;

    countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .btn_pedge (btn_pedge),
        .value     (value),
        .running   (running),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic [15:0] v, input logic r, input logic a);
        exp_t e;
        e.name    = n;
        e.value   = v;
        e.running = r;
        e.alarm   = a;
        return e;
    endfunction

    function automatic vec_t vec(input logic [3:0] b, input string n, input logic [15:0] v,
                                 input logic r, input logic a);
        vec_t t;
        t.btn = b;
        t.e   = mk(n, v, r, a);
        return t;
    endfunction

    task automatic check_front();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        if (value !== e.value || running !== e.running || alarm !== e.alarm) begin
            errors++;
            $display("FAIL %s: got value=%h running=%b alarm=%b, want value=%h running=%b alarm=%b",
                     e.name, value, running, alarm, e.value, e.running, e.alarm);
        end
    endtask

    // Called at a falling edge: drive a one-cycle pulse, compare after the next rising edge.
    task automatic apply(input logic [3:0] b, input exp_t e);
        btn_pedge = b;
        sb.push_back(e);
        @(negedge clk);
        btn_pedge = 4'b0000;
        check_front();
    endtask

    task automatic hold(input int n, input exp_t e);
        sb.push_back(e);
        repeat (n) @(negedge clk);
        check_front();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = vec(4'b0100, "sec_inc_a",        16'h0001, 1'b0, 1'b0);
        tbl[1]  = vec(4'b0100, "sec_inc_b",        16'h0002, 1'b0, 1'b0);
        tbl[2]  = vec(4'b0010, "min_inc",          16'h0102, 1'b0, 1'b0);
        tbl[3]  = vec(4'b0110, "min_over_sec",     16'h0202, 1'b0, 1'b0);
        tbl[4]  = vec(4'b1001, "clear_over_start", 16'h0000, 1'b0, 1'b0);
        tbl[5]  = vec(4'b0001, "start_at_zero",    16'h0000, 1'b0, 1'b0);
        tbl[6]  = vec(4'b0101, "start_over_sec",   16'h0000, 1'b0, 1'b0);
        tbl[7]  = vec(4'b0100, "set_sec_1",        16'h0001, 1'b0, 1'b0);
        tbl[8]  = vec(4'b0100, "set_sec_2",        16'h0002, 1'b0, 1'b0);
        tbl[9]  = vec(4'b0100, "set_sec_3",        16'h0003, 1'b0, 1'b0);
        tbl[10] = vec(4'b0001, "start_run",        16'h0003, 1'b1, 1'b0);
        tbl[11] = vec(4'b0010, "min_ignored_run",  16'h0003, 1'b1, 1'b0);
        tbl[12] = vec(4'b0100, "sec_ignored_run",  16'h0003, 1'b1, 1'b0);

        @(negedge clk);
        hold(0, mk("reset_state", 16'h0000, 1'b0, 1'b0));
        reset_p = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            apply(tbl[i].btn, tbl[i].e);

        // Countdown 00:03 -> alarm; start edge plus two ignored presses already used 3 of 10.
        hold(7,  mk("before_first_tick", 16'h0003, 1'b1, 1'b0));
        hold(1,  mk("tick_0002",         16'h0002, 1'b1, 1'b0));
        hold(10, mk("tick_0001",         16'h0001, 1'b1, 1'b0));
        hold(10, mk("expire_alarm",      16'h0000, 1'b0, 1'b1));
        hold(5,  mk("alarm_held",        16'h0000, 1'b0, 1'b1));
        apply(4'b0010, mk("alarm_exit",  RELOAD,   1'b0, 1'b0));
        apply(4'b1000, mk("clear_idle",  16'h0000, 1'b0, 1'b0));

        // Borrow across the minute boundary.
        apply(4'b0010, mk("set_0100",         16'h0100, 1'b0, 1'b0));
        apply(4'b0001, mk("start_0100",       16'h0100, 1'b1, 1'b0));
        hold(9,  mk("before_borrow",          16'h0100, 1'b1, 1'b0));
        hold(1,  mk("borrow_0059",            16'h0059, 1'b1, 1'b0));

        // Pause after 4 prescaler counts; resume must finish the remaining 6.
        hold(3,  mk("pre_pause",              16'h0059, 1'b1, 1'b0));
        apply(4'b0001, mk("pause",            16'h0059, 1'b0, 1'b0));
        hold(50, mk("paused_hold",            16'h0059, 1'b0, 1'b0));
        apply(4'b0001, mk("resume",           16'h0059, 1'b1, 1'b0));
        hold(5,  mk("resume_before_tick",     16'h0059, 1'b1, 1'b0));
        hold(1,  mk("resume_tick_0058",       16'h0058, 1'b1, 1'b0));

        // Terminal tick together with start/pause: decrement, then PAUSE.
        hold(9,  mk("pre_tick_pause",         16'h0058, 1'b1, 1'b0));
        apply(4'b0001, mk("tick_and_pause",   16'h0057, 1'b0, 1'b0));
        apply(4'b0100, mk("pause_sec_inc",    16'h0058, 1'b0, 1'b0));
        apply(4'b0010, mk("pause_min_inc",    16'h0158, 1'b0, 1'b0));
        apply(4'b0001, mk("resume_0158",      16'h0158, 1'b1, 1'b0));
        apply(4'b1001, mk("clear_start_run",  16'h0000, 1'b0, 1'b0));

        // Seconds wrap 59->00 without touching minutes, then minutes wrap.
        for (int s = 1; s <= 60; s++) begin
            logic [15:0] ev;
            ev = {8'h00, 4'((s % 60) / 10), 4'(s % 10)};
            apply(4'b0100, mk("sec_wrap_walk", ev, 1'b0, 1'b0));
        end
        for (int m = 1; m <= 60; m++) begin
            logic [15:0] ev;
            ev = {4'((m % 60) / 10), 4'(m % 10), 8'h00};
            apply(4'b0010, mk("min_wrap_walk", ev, 1'b0, 1'b0));
        end

        // Asynchronous reset in the middle of a countdown.
        apply(4'b0100, mk("set_0001",         16'h0001, 1'b0, 1'b0));
        apply(4'b0001, mk("start_0001",       16'h0001, 1'b1, 1'b0));
        hold(5,  mk("running_0001",           16'h0001, 1'b1, 1'b0));
        #2 reset_p = 1'b1;
        #1 hold(0, mk("async_reset",          16'h0000, 1'b0, 1'b0));
        @(negedge clk);
        reset_p = 1'b0;
        hold(30, mk("no_alarm_after_reset",   16'h0000, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
